// File: rtl/fifo_ctrl.sv
// Single-clock FIFO controller sequencing an external dual-port RAM.
// Optional sticky overflow/underflow flags enabled by FIFO_CTRL_ERR_EN.
module fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int RAM_DEPTH  = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  push_ready,
  input  logic                  pop,
  output logic                  pop_ready,
  output logic                  pop_valid,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  ram_w_en,
  output logic [ADDR_WIDTH-1:0] ram_w_addr,
  output logic [DATA_WIDTH-1:0] ram_w_data,
  output logic                  ram_r_en,
  output logic [ADDR_WIDTH-1:0] ram_r_addr,
  input  logic [DATA_WIDTH-1:0] ram_r_data,
  input  logic                  err_clr,
  output logic                  err_ovf,
  output logic                  err_udf
);

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH =
    (ADDR_WIDTH + 1)'(RAM_DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_ptr_nx;
  logic [ADDR_WIDTH-1:0] rd_ptr_nx;
  logic [ADDR_WIDTH:0]   count_nx;
  logic                  push_acc;
  logic                  pop_acc;

  assign full       = (count == DEPTH);
  assign empty      = (count == '0);
  assign pop_acc    = pop & ~empty;
  assign push_acc   = push & (~full | pop_acc);
  assign push_ready = ~full | pop;
  assign pop_ready  = ~empty;

  assign ram_w_en   = push_acc;
  assign ram_w_addr = wr_ptr;
  assign ram_w_data = push_data;
  assign ram_r_en   = pop_acc;
  assign ram_r_addr = rd_ptr;
  assign pop_data   = ram_r_data;

  // Pointers wrap at RAM_DEPTH, which need not be a power of two.
  always_comb begin
    wr_ptr_nx = wr_ptr;
    rd_ptr_nx = rd_ptr;
    if (push_acc)
      wr_ptr_nx = (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
    if (pop_acc)
      rd_ptr_nx = (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
  end

  always_comb begin
    count_nx = count;
    unique case ({push_acc, pop_acc})
      2'b10:   count_nx = count + 1'b1;
      2'b01:   count_nx = count - 1'b1;
      default: count_nx = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pop_valid <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_nx;
      rd_ptr    <= rd_ptr_nx;
      count     <= count_nx;
      pop_valid <= pop_acc;
    end
  end

`ifdef FIFO_CTRL_ERR_EN
  logic ovf_evt;
  logic udf_evt;

  assign ovf_evt = push & ~push_acc;
  assign udf_evt = pop & empty;

  // A fresh event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      err_ovf <= ovf_evt | (err_ovf & ~err_clr);
      err_udf <= udf_evt | (err_udf & ~err_clr);
    end
  end
`else
  logic err_clr_unused;

  assign err_clr_unused = err_clr;
  assign err_ovf        = 1'b0;
  assign err_udf        = 1'b0;
`endif

endmodule
